data_in_sched: RTL and testbench

Frame scheduler for the input-data path. Gathers one `WORD_W`-bit word from each of `LANES` producer lanes through valid/ready handshakes into a local bank. Then streams the bank cyclically (slot 0,1,…,LANES-1,0,…) as a `FRAME_LEN`-beat frame to the downstream consumer under valid/ready flow control. It replaces free-running `run`-gated word rotation with an explicit load/stream/done sequence, back-pressure and abort.

---
 rtl/data_in_sched_if.sv | 32 +++
 rtl/data_in_sched.sv | 73 +++++++
 tb/tb_data_in_sched.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/data_in_sched_if.sv
// data_in_sched_if: lane capture and frame output bundle for data_in_sched
`ifndef BIT_LENGTH
`define BIT_LENGTH 8
`endif
`ifndef DATA_N
`define DATA_N 1
`endif
interface data_in_sched_if #(
  parameter int WORD_W = `BIT_LENGTH*`DATA_N,
  parameter int LANES  = 4
);
  logic                    start;
  logic                    abort;
  logic [LANES-1:0]        lane_valid;
  logic [LANES*WORD_W-1:0] lane_data;
  logic [LANES-1:0]        lane_ready;
  logic                    out_valid;
  logic                    out_ready;
  logic [WORD_W-1:0]       out_data;
  logic [15:0]             out_beat;
  logic                    out_last;
  logic                    busy;
  logic                    frame_done;
  modport master (
    output start, abort, lane_valid, lane_data, out_ready,
    input  lane_ready, out_valid, out_data, out_beat, out_last, busy, frame_done
  );
  modport slave (
    input  start, abort, lane_valid, lane_data, out_ready,
    output lane_ready, out_valid, out_data, out_beat, out_last, busy, frame_done
  );
endinterface

// File: rtl/data_in_sched.sv
// data_in_sched: gathers one word per lane into a bank, then streams it cyclically as a frame
`ifndef BIT_LENGTH
`define BIT_LENGTH 8
`endif
`ifndef DATA_N
`define DATA_N 1
`endif
module data_in_sched #(
  parameter int WORD_W    = `BIT_LENGTH*`DATA_N,
  parameter int LANES     = 4,
  parameter int FRAME_LEN = 102
) (
  input logic clk,
  input logic rst,
  data_in_sched_if.slave bus
);
  typedef enum logic [1:0] {IDLE, LOAD, STREAM, DONE} state_t;
  localparam int SW = $clog2(LANES);
  localparam logic [SW-1:0] SLOT_MAX = SW'(LANES-1);
  localparam logic [15:0] BEAT_MAX = 16'(FRAME_LEN-1);
  state_t            state;
  logic [LANES-1:0]  loaded;
  logic [LANES-1:0]  cap;
  logic [WORD_W-1:0] bank [LANES];
  logic [SW-1:0]     slot;
  logic [15:0]       beat;
  assign cap = bus.lane_valid & bus.lane_ready;
  // Outputs decode only registered state, so no input reaches them combinationally.
  assign bus.lane_ready = (state == LOAD) ? ~loaded : '0;
  assign bus.out_valid  = state == STREAM;
  assign bus.out_data   = (state == STREAM) ? bank[slot] : '0;
  assign bus.out_beat   = (state == STREAM) ? beat : '0;
  assign bus.out_last   = (state == STREAM) && (beat == BEAT_MAX);
  assign bus.busy       = state != IDLE;
  assign bus.frame_done = state == DONE;
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      loaded <= '0;
      slot   <= '0;
      beat   <= '0;
      for (int i = 0; i < LANES; i++) bank[i] <= '0;
    end else if (bus.abort) begin
      state  <= IDLE;
      loaded <= '0;
      slot   <= '0;
      beat   <= '0;
    end else begin
      case (state)
        IDLE: if (bus.start) begin
          state  <= LOAD;
          loaded <= '0;
        end
        LOAD: begin
          for (int i = 0; i < LANES; i++)
            if (cap[i]) bank[i] <= bus.lane_data[i*WORD_W +: WORD_W];
          loaded <= loaded | cap;
          if (&(loaded | cap)) begin
            state <= STREAM;
            slot  <= '0;
            beat  <= '0;
          end
        end
        STREAM: if (bus.out_ready) begin
          slot <= (slot == SLOT_MAX) ? '0 : slot + 1'b1;
          beat <= beat + 16'd1;
          if (beat == BEAT_MAX) state <= DONE;
        end
        DONE: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_data_in_sched.sv
// tb_data_in_sched: directed scenarios with a beat scoreboard for data_in_sched
module tb_data_in_sched;
  localparam int W = 8;
  localparam int L = 4;
  localparam int FL = 102;
  typedef struct packed {
    logic [W-1:0] d;
    logic [15:0]  b;
    logic         l;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_assert = 0;
  int n_fail = 0;
  exp_t sb[$];
  bit held = 0;
  logic [W-1:0] hd;
  logic [15:0] hb;
  logic hl;
  data_in_sched_if #(.WORD_W(W), .LANES(L)) bus ();
  data_in_sched #(.WORD_W(W), .LANES(L), .FRAME_LEN(FL)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic push_frame(input logic [L*W-1:0] w);
    exp_t e;
    for (int b = 0; b < FL; b++) begin
      e.d = w[(b % L)*W +: W];
      e.b = 16'(b);
      e.l = (b == FL-1);
      sb.push_back(e);
    end
  endtask
  task automatic cyc();
    exp_t e;
    if (held) begin
      chk("stall_valid", bus.out_valid, 1);
      chk("stall_data", bus.out_data, hd);
      chk("stall_beat", bus.out_beat, hb);
      chk("stall_last", bus.out_last, hl);
    end
    held = bus.out_valid && !bus.out_ready;
    hd = bus.out_data;
    hb = bus.out_beat;
    hl = bus.out_last;
    if (bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) chk("unexpected_beat", 1, 0);
      else begin
        e = sb.pop_front();
        chk("beat_data", bus.out_data, e.d);
        chk("beat_index", bus.out_beat, e.b);
        chk("beat_last", bus.out_last, e.l);
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic run_frame(input bit rnd);
    int n = 0;
    while (!bus.frame_done && n < 2000) begin
      if (rnd) bus.out_ready = 1'($urandom_range(0, 1));
      cyc();
      n++;
    end
    chk("frame_done_seen", bus.frame_done, 1);
    chk("sb_empty", sb.size(), 0);
    chk("done_valid_low", bus.out_valid, 0);
    bus.out_ready = 1'b1;
    cyc();
    chk("done_one_cycle", bus.frame_done, 0);
    chk("busy_fall", bus.busy, 0);
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, "_lane_ready"}, bus.lane_ready, 0);
    chk({tag, "_out_valid"}, bus.out_valid, 0);
    chk({tag, "_out_data"}, bus.out_data, 0);
    chk({tag, "_out_beat"}, bus.out_beat, 0);
    chk({tag, "_out_last"}, bus.out_last, 0);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_frame_done"}, bus.frame_done, 0);
  endtask
  initial begin
    bus.start = 0;
    bus.abort = 0;
    bus.lane_valid = '0;
    bus.lane_data = '0;
    bus.out_ready = 1;
    repeat (2) @(negedge clk);
    chk_zero("reset");
    rst = 0;
    // basic frame, all lanes valid up front
    bus.lane_data = 32'hA3A2A1A0;
    bus.lane_valid = 4'hF;
    bus.start = 1;
    push_frame(32'hA3A2A1A0);
    cyc();
    bus.start = 0;
    chk("load_busy", bus.busy, 1);
    chk("load_ready_all", bus.lane_ready, 4'hF);
    chk("load_valid_low", bus.out_valid, 0);
    chk("load_data_zero", bus.out_data, 0);
    cyc();
    chk("stream_start", bus.out_valid, 1);
    bus.lane_valid = '0;
    run_frame(0);
    // staggered load: lane 2, then 0+3 (with a stale retry on 2), then 1
    bus.start = 1;
    cyc();
    bus.start = 0;
    bus.lane_data = 32'hB3B2B1B0;
    bus.lane_valid = 4'b0100;
    push_frame(32'hB3B2B1B0);
    cyc();
    chk("stag_ready_1", bus.lane_ready, 4'b1011);
    bus.lane_data = 32'hB3EEB1B0;
    bus.lane_valid = 4'b1101;
    cyc();
    chk("stag_ready_2", bus.lane_ready, 4'b0010);
    chk("stag_valid_low", bus.out_valid, 0);
    chk("stag_data_zero", bus.out_data, 0);
    bus.lane_valid = 4'b0010;
    cyc();
    chk("stag_stream", bus.out_valid, 1);
    chk("stag_ready_none", bus.lane_ready, 0);
    bus.lane_valid = '0;
    run_frame(0);
    // back-pressure
    bus.lane_data = 32'hC3C2C1C0;
    bus.lane_valid = 4'hF;
    bus.start = 1;
    push_frame(32'hC3C2C1C0);
    cyc();
    bus.start = 0;
    cyc();
    bus.lane_valid = '0;
    run_frame(1);
    // abort at beat 50
    bus.lane_data = 32'hD3D2D1D0;
    bus.lane_valid = 4'hF;
    bus.start = 1;
    push_frame(32'hD3D2D1D0);
    cyc();
    bus.start = 0;
    cyc();
    for (int n = 0; n < 200 && !(bus.out_valid && bus.out_beat == 16'd50); n++) cyc();
    chk("abort_reach_50", bus.out_beat, 50);
    bus.abort = 1;
    @(posedge clk);
    @(negedge clk);
    bus.abort = 0;
    sb.delete();
    held = 0;
    chk("abort_valid", bus.out_valid, 0);
    chk("abort_busy", bus.busy, 0);
    chk("abort_done", bus.frame_done, 0);
    cyc();
    chk("abort_done_late", bus.frame_done, 0);
    // fresh frame after abort, with a stray start mid-stream
    bus.start = 1;
    push_frame(32'hD3D2D1D0);
    cyc();
    bus.start = 0;
    cyc();
    repeat (10) cyc();
    bus.start = 1;
    cyc();
    bus.start = 0;
    run_frame(0);
    // start together with abort
    bus.start = 1;
    bus.abort = 1;
    cyc();
    bus.start = 0;
    bus.abort = 0;
    chk("sa_busy", bus.busy, 0);
    chk("sa_ready", bus.lane_ready, 0);
    cyc();
    chk("sa_busy_late", bus.busy, 0);
    // reset mid-load
    bus.lane_valid = '0;
    bus.start = 1;
    cyc();
    bus.start = 0;
    bus.lane_data = 32'hE3E2E1E0;
    bus.lane_valid = 4'b0011;
    cyc();
    chk("rst_partial", bus.lane_ready, 4'b1100);
    bus.lane_valid = '0;
    rst = 1;
    cyc();
    chk_zero("midrst");
    rst = 0;
    bus.start = 1;
    cyc();
    bus.start = 0;
    chk("reload_ready", bus.lane_ready, 4'hF);
    cyc();
    chk("reload_hold", bus.lane_ready, 4'hF);
    chk("reload_no_stream", bus.out_valid, 0);
    bus.lane_data = 32'hF3F2F1F0;
    bus.lane_valid = 4'hF;
    push_frame(32'hF3F2F1F0);
    cyc();
    chk("reload_stream", bus.out_valid, 1);
    bus.lane_valid = '0;
    run_frame(0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
